// File: rtl/lives_manager.sv
// lives_manager: player life counter, post-hit invulnerability window and sprite blink gate.
// Define LIVES_EXTRA_LIFE_EN to add the extra_life input (saturating life grants).
module lives_manager #(
  parameter int INIT_LIVES    = 3,
  parameter int MAX_LIVES     = 7,
  parameter int INVULN_CYCLES = 50_000_000,
  parameter int BLINK_PERIOD  = 4_000_000
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       restartN,
  input  logic       enable,
  input  logic       player_hit,
`ifdef LIVES_EXTRA_LIFE_EN
  input  logic       extra_life,
`endif
  output logic       player_dead,
  output logic [2:0] lives_left,
  output logic       invulnerable,
  output logic       player_visible
);

  localparam int TIMER_W = (INVULN_CYCLES > 1) ? $clog2(INVULN_CYCLES) : 1;
  localparam int BLINK_W = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;

  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(INVULN_CYCLES - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_PERIOD - 1);
  localparam logic [2:0]         LIVES_INIT = 3'(INIT_LIVES);
  localparam logic [2:0]         LIVES_MAX  = 3'(MAX_LIVES);

  typedef enum logic [1:0] {
    ST_ALIVE  = 2'd0,
    ST_INVULN = 2'd1,
    ST_DEAD   = 2'd2
  } state_t;

  state_t             r_state;
  logic [2:0]         r_lives;
  logic [TIMER_W-1:0] r_timer;
  logic [BLINK_W-1:0] r_blink_cnt;
  logic               r_blink_phase;
  logic               r_hit_d;

  state_t             w_state_nxt;
  logic [2:0]         w_lives_nxt;
  logic [TIMER_W-1:0] w_timer_nxt;
  logic [BLINK_W-1:0] w_blink_cnt_nxt;
  logic               w_blink_phase_nxt;
  logic               w_enter_invuln;
  logic               w_hit_edge;
  logic               w_extra;
  logic [2:0]         w_lives_inc;

  assign w_hit_edge = player_hit & ~r_hit_d & enable;

`ifdef LIVES_EXTRA_LIFE_EN
  assign w_extra = extra_life & enable;
`else
  assign w_extra = 1'b0;
`endif

  assign w_lives_inc = (r_lives < LIVES_MAX) ? r_lives + 3'd1 : r_lives;

  // NOTE: every next-state signal gets a default first so no path through the
  // case statement leaves one unassigned, which would infer a latch.
  always_comb begin
    w_state_nxt       = r_state;
    w_lives_nxt       = r_lives;
    w_timer_nxt       = r_timer;
    w_blink_cnt_nxt   = r_blink_cnt;
    w_blink_phase_nxt = r_blink_phase;
    w_enter_invuln    = 1'b0;

    if (!restartN) begin
      w_state_nxt       = ST_ALIVE;
      w_lives_nxt       = LIVES_INIT;
      w_timer_nxt       = '0;
      w_blink_cnt_nxt   = '0;
      w_blink_phase_nxt = 1'b0;
    end else begin
      unique case (r_state)
        ST_ALIVE: begin
          if (w_hit_edge) begin
            // A life granted in the same cycle as a hit always cancels the fatal case.
            if (w_extra) begin
              w_lives_nxt    = (r_lives == LIVES_MAX) ? LIVES_MAX - 3'd1 : r_lives;
              w_enter_invuln = 1'b1;
            end else if (r_lives == 3'd1) begin
              w_lives_nxt = 3'd0;
              w_state_nxt = ST_DEAD;
            end else begin
              w_lives_nxt    = r_lives - 3'd1;
              w_enter_invuln = 1'b1;
            end
          end else if (w_extra) begin
            w_lives_nxt = w_lives_inc;
          end
        end
        ST_INVULN: begin
          if (w_extra) w_lives_nxt = w_lives_inc;
          if (enable) begin
            if (r_timer == '0) w_state_nxt = ST_ALIVE;
            else               w_timer_nxt = r_timer - 1'b1;
            if (r_blink_cnt == BLINK_LAST) begin
              w_blink_cnt_nxt   = '0;
              w_blink_phase_nxt = ~r_blink_phase;
            end else begin
              w_blink_cnt_nxt = r_blink_cnt + 1'b1;
            end
          end
        end
        ST_DEAD: ;
        default: w_state_nxt = ST_ALIVE;
      endcase

      if (w_enter_invuln) begin
        w_state_nxt       = ST_INVULN;
        w_timer_nxt       = TIMER_LOAD;
        w_blink_cnt_nxt   = '0;
        w_blink_phase_nxt = 1'b0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state       <= ST_ALIVE;
      r_lives       <= LIVES_INIT;
      r_timer       <= '0;
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
      r_hit_d       <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_lives       <= w_lives_nxt;
      r_timer       <= w_timer_nxt;
      r_blink_cnt   <= w_blink_cnt_nxt;
      r_blink_phase <= w_blink_phase_nxt;
      // Tracks the level even when paused or restarting, so held levels never replay as edges.
      r_hit_d       <= player_hit;
    end
  end

  assign player_dead    = (r_state == ST_DEAD);
  assign invulnerable   = (r_state == ST_INVULN);
  assign lives_left     = r_lives;
  assign player_visible = (r_state == ST_ALIVE) | ((r_state == ST_INVULN) & ~r_blink_phase);

endmodule

// File: tb/tb_lives_manager.sv
// Self-checking bench for lives_manager: per-cycle expected output vectors are queued
// when stimulus is driven and popped for comparison after the following clock edge.
module tb_lives_manager;

  localparam int INIT_LIVES    = 3;
  localparam int MAX_LIVES     = 7;
  localparam int INVULN_CYCLES = 8;
  localparam int BLINK_PERIOD  = 2;

  logic       clk = 1'b0;
  logic       resetN;
  logic       restartN;
  logic       enable;
  logic       player_hit;
`ifdef LIVES_EXTRA_LIFE_EN
  logic       extra_life;
`endif
  logic       player_dead;
  logic [2:0] lives_left;
  logic       invulnerable;
  logic       player_visible;

  int n_checks = 0;
  int n_errors = 0;

  // {lives_left, player_dead, invulnerable, player_visible}
  logic [5:0] sb_q[$];

  lives_manager #(
    .INIT_LIVES   (INIT_LIVES),
    .MAX_LIVES    (MAX_LIVES),
    .INVULN_CYCLES(INVULN_CYCLES),
    .BLINK_PERIOD (BLINK_PERIOD)
  ) dut (
    .clk           (clk),
    .resetN        (resetN),
    .restartN      (restartN),
    .enable        (enable),
    .player_hit    (player_hit),
`ifdef LIVES_EXTRA_LIFE_EN
    .extra_life    (extra_life),
`endif
    .player_dead   (player_dead),
    .lives_left    (lives_left),
    .invulnerable  (invulnerable),
    .player_visible(player_visible)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] mk(input int lives, input logic dead, input logic inv,
                                    input logic vis);
    return {3'(lives), dead, inv, vis};
  endfunction

  // Expected outputs j cycles after entering INVULN (j = 0 is the first INVULN cycle).
  function automatic logic [5:0] inv_exp(input int lives, input int j);
    if (j < INVULN_CYCLES) return mk(lives, 1'b0, 1'b1, ((j / BLINK_PERIOD) % 2) == 0);
    return mk(lives, 1'b0, 1'b0, 1'b1);
  endfunction

  function automatic logic [5:0] observed();
    return {lives_left, player_dead, invulnerable, player_visible};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetN     = 1'b0;
    restartN   = 1'b1;
    enable     = 1'b1;
    player_hit = 1'b0;
`ifdef LIVES_EXTRA_LIFE_EN
    extra_life = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetN = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    logic [5:0] got, want;
    resetN     = 1'b1;
    restartN   = 1'b1;
    enable     = 1'b1;
    player_hit = 1'b0;
`ifdef LIVES_EXTRA_LIFE_EN
    extra_life = 1'b0;
`endif
    #2 resetN = 1'b0;
    sb_q.push_back(mk(INIT_LIVES, 1'b0, 1'b0, 1'b1));
    #1;
    got = observed(); want = sb_q.pop_front(); n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL reset_async got=%b want=%b", got, want);
    end
    sb_q.push_back(mk(INIT_LIVES, 1'b0, 1'b0, 1'b1));
    tick();
    got = observed(); want = sb_q.pop_front(); n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL reset_held got=%b want=%b", got, want);
    end
    do_reset();
  endtask

  task automatic test_basic_hit();
    logic [5:0] got, want;
    do_reset();
    for (int j = 0; j <= INVULN_CYCLES + 1; j++) begin
      player_hit = (j == 0);
      sb_q.push_back(inv_exp(INIT_LIVES - 1, j));
      tick();
      got = observed(); want = sb_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_errors++;
        $display("FAIL basic_hit cycle=%0d got=%b want=%b", j, got, want);
      end
    end
    player_hit = 1'b0;
  endtask

  task automatic test_hit_masking();
    logic [5:0] got, want;
    do_reset();
    // Held level with a one-cycle dip: the second rising edge lands inside INVULN.
    for (int k = 0; k < 22; k++) begin
      player_hit = (k != 3);
      sb_q.push_back(inv_exp(INIT_LIVES - 1, k));
      tick();
      got = observed(); want = sb_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_errors++;
        $display("FAIL hit_masking cycle=%0d got=%b want=%b", k, got, want);
      end
    end
    player_hit = 1'b0;
    tick();
  endtask

  task automatic test_three_hits();
    logic [5:0] got, want;
    do_reset();
    for (int h = 0; h < 3; h++) begin
      for (int j = 0; j <= INVULN_CYCLES + 2; j++) begin
        player_hit = (j == 0);
        sb_q.push_back((h < 2) ? inv_exp(INIT_LIVES - 1 - h, j) : mk(0, 1'b1, 1'b0, 1'b0));
        tick();
        got = observed(); want = sb_q.pop_front(); n_checks++;
        if (got !== want) begin
          n_errors++;
          $display("FAIL three_hits hit=%0d cycle=%0d got=%b want=%b", h, j, got, want);
        end
      end
    end
    for (int j = 0; j < 4; j++) begin
      player_hit = (j == 0);
`ifdef LIVES_EXTRA_LIFE_EN
      extra_life = (j == 1);
`endif
      sb_q.push_back(mk(0, 1'b1, 1'b0, 1'b0));
      tick();
      got = observed(); want = sb_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_errors++;
        $display("FAIL dead_ignores cycle=%0d got=%b want=%b", j, got, want);
      end
    end
  endtask

  task automatic test_pause();
    logic [5:0] got, want;
    do_reset();
    for (int j = 0; j < 4; j++) begin
      player_hit = (j == 0);
      sb_q.push_back(inv_exp(2, j));
      tick();
      got = observed(); want = sb_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_errors++;
        $display("FAIL pause_entry cycle=%0d got=%b want=%b", j, got, want);
      end
    end
    enable = 1'b0;
    for (int j = 0; j < 10; j++) begin
      sb_q.push_back(inv_exp(2, 3));
      tick();
      got = observed(); want = sb_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_errors++;
        $display("FAIL pause_frozen cycle=%0d got=%b want=%b", j, got, want);
      end
    end
    enable = 1'b1;
    for (int m = 1; m <= 5; m++) begin
      sb_q.push_back(inv_exp(2, 3 + m));
      tick();
      got = observed(); want = sb_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_errors++;
        $display("FAIL pause_resume cycle=%0d got=%b want=%b", m, got, want);
      end
    end
    // A rising edge while paused is lost and must not replay after enable returns.
    for (int j = 0; j < 6; j++) begin
      enable     = (j >= 2);
      player_hit = (j < 5);
      sb_q.push_back(mk(2, 1'b0, 1'b0, 1'b1));
      tick();
      got = observed(); want = sb_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_errors++;
        $display("FAIL pause_lost_edge cycle=%0d got=%b want=%b", j, got, want);
      end
    end
  endtask

`ifdef LIVES_EXTRA_LIFE_EN
  task automatic test_extra_life();
    logic [5:0] got, want;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      extra_life = (k % 2 == 0);
      sb_q.push_back(mk((INIT_LIVES + k / 2 + 1 > MAX_LIVES) ? MAX_LIVES : INIT_LIVES + k / 2 + 1,
                        1'b0, 1'b0, 1'b1));
      tick();
      got = observed(); want = sb_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_errors++;
        $display("FAIL extra_sat cycle=%0d got=%b want=%b", k, got, want);
      end
    end
    player_hit = 1'b1;
    extra_life = 1'b1;
    sb_q.push_back(inv_exp(MAX_LIVES - 1, 0));
    tick();
    got = observed(); want = sb_q.pop_front(); n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL extra_hit_at_max got=%b want=%b", got, want);
    end
    player_hit = 1'b0;
    extra_life = 1'b0;

    do_reset();
    for (int h = 0; h < 2; h++) begin
      for (int j = 0; j <= INVULN_CYCLES + 1; j++) begin
        player_hit = (j == 0);
        sb_q.push_back(inv_exp(INIT_LIVES - 1 - h, j));
        tick();
        got = observed(); want = sb_q.pop_front(); n_checks++;
        if (got !== want) begin
          n_errors++;
          $display("FAIL extra_setup hit=%0d cycle=%0d got=%b want=%b", h, j, got, want);
        end
      end
    end
    for (int j = 0; j <= INVULN_CYCLES + 1; j++) begin
      player_hit = (j == 0);
      extra_life = (j <= 2);
      enable     = (j != 2);
      // Hit plus grant at one life: INVULN at 1, then a grant during INVULN gives 2;
      // the grant in the paused cycle is ignored and the window is frozen there.
      sb_q.push_back(inv_exp((j == 0) ? 1 : 2, (j >= 2) ? j - 1 : j));
      tick();
      got = observed(); want = sb_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_errors++;
        $display("FAIL extra_hit_same_cycle cycle=%0d got=%b want=%b", j, got, want);
      end
    end
    extra_life = 1'b0;
    enable     = 1'b1;
  endtask
`endif

  task automatic test_restart();
    logic [5:0] got, want;
    do_reset();
    for (int h = 0; h < 3; h++) begin
      player_hit = 1'b1;
      tick();
      player_hit = 1'b0;
      repeat (INVULN_CYCLES + 2) tick();
    end
    sb_q.push_back(mk(0, 1'b1, 1'b0, 1'b0));
    got = observed(); want = sb_q.pop_front(); n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL restart_setup_dead got=%b want=%b", got, want);
    end
    for (int j = 0; j < 6; j++) begin
      player_hit = (j != 4);
      restartN   = (j != 0);
      sb_q.push_back((j < 5) ? mk(INIT_LIVES, 1'b0, 1'b0, 1'b1) : inv_exp(INIT_LIVES - 1, 0));
      tick();
      got = observed(); want = sb_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_errors++;
        $display("FAIL restart_held cycle=%0d got=%b want=%b", j, got, want);
      end
    end
    // Restart mid-INVULN, then a fresh hit must get a full-length window.
    for (int j = 0; j < 3 + INVULN_CYCLES; j++) begin
      restartN   = (j != 0);
      player_hit = (j == 2);
      sb_q.push_back((j < 2) ? mk(INIT_LIVES, 1'b0, 1'b0, 1'b1) : inv_exp(INIT_LIVES - 1, j - 2));
      tick();
      got = observed(); want = sb_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_errors++;
        $display("FAIL restart_mid_invuln cycle=%0d got=%b want=%b", j, got, want);
      end
    end
    player_hit = 1'b0;
  endtask

  task automatic test_mid_reset();
    logic [5:0] got, want;
    do_reset();
    for (int j = 0; j < 3; j++) begin
      player_hit = (j == 0);
      tick();
    end
    player_hit = 1'b0;
    #2 resetN = 1'b0;
    sb_q.push_back(mk(INIT_LIVES, 1'b0, 1'b0, 1'b1));
    #1;
    got = observed(); want = sb_q.pop_front(); n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL mid_reset_async got=%b want=%b", got, want);
    end
    @(negedge clk);
    resetN = 1'b1;
    for (int j = 0; j < 3; j++) begin
      sb_q.push_back(mk(INIT_LIVES, 1'b0, 1'b0, 1'b1));
      tick();
      got = observed(); want = sb_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_errors++;
        $display("FAIL mid_reset_after cycle=%0d got=%b want=%b", j, got, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_hit();
    test_hit_masking();
    test_three_hits();
    test_pause();
`ifdef LIVES_EXTRA_LIFE_EN
    test_extra_life();
`endif
    test_restart();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    n_errors++;
    $display("FAIL watchdog timeout got=running want=done");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
